// File: rtl/wb_master_arbiter_pkg.sv
// Shared constants, state type and round-robin helper for the inner-interconnect
// Wishbone master arbiter (icache_0, icache_1, dcache -> inner_wb_*).
package wb_master_arbiter_pkg;

    localparam int WB_ADDR_W = 24;
    localparam int WB_DATA_W = 16;

    // Master indices; WB_M_NONE marks an idle bus on o_owner.
    localparam logic [1:0] WB_M_IC0  = 2'd0;
    localparam logic [1:0] WB_M_IC1  = 2'd1;
    localparam logic [1:0] WB_M_DC   = 2'd2;
    localparam logic [1:0] WB_M_NONE = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Successor in the round-robin ring 0 -> 1 -> 2 -> 0; NONE restarts at 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            WB_M_IC0: nxt = WB_M_IC1;
            WB_M_IC1: nxt = WB_M_DC;
            default:  nxt = WB_M_IC0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters: the first requester
// following the last owner wins, so the previous owner always ranks last.
module wb_master_arbiter_rr_pick3
    import wb_master_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_gnt,
    output logic       o_valid
);

    logic [1:0] w_cand;

    // Walk the ring starting after the last owner and keep the first hit.
    always_comb begin
        o_gnt   = WB_M_NONE;
        o_valid = 1'b0;
        w_cand  = i_last;
        for (int k = 0; k < 3; k++) begin
            w_cand = rr_next(w_cand);
            if (!o_valid && i_req[w_cand]) begin
                o_gnt   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// 3-master -> 1-slave Wishbone arbiter. Ownership is held for a whole cyc so
// bursts are never split, and every handover inserts one idle bus cycle.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort an owner that waits
// TMO strobe cycles without ack/err.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int AW = WB_ADDR_W,
    parameter int DW = WB_DATA_W
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TMO = 255
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_disable,
    input  logic [2:0]      m_cyc,
    input  logic [2:0]      m_stb,
    input  logic [2:0]      m_we,
    input  logic [3*AW-1:0] m_adr,
    input  logic [3*DW-1:0] m_dat_w,
    input  logic [5:0]      m_sel,
    input  logic [2:0]      m_4_burst,
    input  logic [2:0]      m_8_burst,
    output logic [2:0]      m_ack,
    output logic [2:0]      m_err,
    output logic [DW-1:0]   m_dat_r,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic [1:0]      s_sel,
    output logic            s_4_burst,
    output logic            s_8_burst,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic [DW-1:0]   s_dat_r,
    output logic [1:0]      o_owner
);

    localparam int NM = 3;

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [1:0]    r_owner;
    logic [1:0]    w_owner_nxt;
    logic [1:0]    r_last;
    logic [1:0]    w_last_nxt;
    logic [1:0]    w_pick;
    logic          w_pick_valid;
    logic          w_timeout;

    logic          w_own_cyc;
    logic          w_own_stb;
    logic          w_own_we;
    logic [AW-1:0] w_own_adr;
    logic [DW-1:0] w_own_dat;
    logic [1:0]    w_own_sel;
    logic          w_own_b4;
    logic          w_own_b8;

    wb_master_arbiter_rr_pick3 u_pick (
        .i_req   (m_cyc),
        .i_last  (r_last),
        .o_gnt   (w_pick),
        .o_valid (w_pick_valid)
    );

    // Select the owning master's request signals; everything is zero when idle.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_dat = '0;
        w_own_sel = '0;
        w_own_b4  = 1'b0;
        w_own_b8  = 1'b0;
        if (r_state == ST_OWN) begin
            for (int n = 0; n < NM; n++) begin
                if (r_owner == 2'(n)) begin
                    w_own_cyc = m_cyc[n];
                    w_own_stb = m_stb[n];
                    w_own_we  = m_we[n];
                    w_own_adr = m_adr[n*AW +: AW];
                    w_own_dat = m_dat_w[n*DW +: DW];
                    w_own_sel = m_sel[n*2 +: 2];
                    w_own_b4  = m_4_burst[n];
                    w_own_b8  = m_8_burst[n];
                end
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] r_wdog;

    // The watchdog fires on the strobe cycle at which the wait would reach TMO.
    assign w_timeout = (r_state == ST_OWN) && w_own_stb && !s_ack && !s_err &&
                       (r_wdog == 8'(TMO - 1));

    // Count unanswered strobe cycles of the owner; any response or state change restarts it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wdog <= 8'd0;
        end else if (r_state != ST_OWN || w_state_nxt != ST_OWN || s_ack || s_err) begin
            r_wdog <= 8'd0;
        end else if (w_own_stb) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State, owner and round-robin pointer; reset leaves M2 as last so M0 wins first.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= WB_M_NONE;
            r_last  <= WB_M_DC;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Grant from idle unless disabled; release when the owner drops cyc or times out.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (!i_disable && w_pick_valid) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_pick;
                end
            end
            ST_OWN: begin
                if (!w_own_cyc || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = WB_M_NONE;
                    w_last_nxt  = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = WB_M_NONE;
            end
        endcase
    end

    // Drive the slave bus from the owner and route responses back to the owner only.
    always_comb begin
        s_cyc     = w_own_cyc & ~w_timeout;
        s_stb     = w_own_stb & ~w_timeout;
        s_we      = w_own_we;
        s_adr     = w_own_adr;
        s_dat_w   = w_own_dat;
        s_sel     = w_own_sel;
        s_4_burst = w_own_b4;
        s_8_burst = w_own_b8;
        m_dat_r   = s_dat_r;
        o_owner   = r_owner;
        m_ack     = '0;
        m_err     = '0;
        if (r_state == ST_OWN) begin
            for (int n = 0; n < NM; n++) begin
                if (r_owner == 2'(n)) begin
                    m_ack[n] = s_ack;
                    m_err[n] = s_err | w_timeout;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter (default build, watchdog disabled).
// A rule-level ownership model predicts every bus output each cycle.
module tb_wb_master_arbiter;
    import wb_master_arbiter_pkg::*;

    localparam int AW = WB_ADDR_W;
    localparam int DW = WB_DATA_W;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_disable;
    logic [2:0]      m_cyc, m_stb, m_we, m_4_burst, m_8_burst;
    logic [3*AW-1:0] m_adr;
    logic [3*DW-1:0] m_dat_w;
    logic [5:0]      m_sel;
    logic [2:0]      m_ack, m_err;
    logic [DW-1:0]   m_dat_r;
    logic            s_cyc, s_stb, s_we, s_4_burst, s_8_burst;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [1:0]      s_sel;
    logic            s_ack, s_err;
    logic [DW-1:0]   s_dat_r;
    logic [1:0]      o_owner;

    int errCount   = 0;
    int checkCount = 0;
    int mOwner     = 3;
    int mLast      = 2;

    wb_master_arbiter dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_disable (i_disable),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_adr     (m_adr),
        .m_dat_w   (m_dat_w),
        .m_sel     (m_sel),
        .m_4_burst (m_4_burst),
        .m_8_burst (m_8_burst),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .m_dat_r   (m_dat_r),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_adr     (s_adr),
        .s_dat_w   (s_dat_w),
        .s_sel     (s_sel),
        .s_4_burst (s_4_burst),
        .s_8_burst (s_8_burst),
        .s_ack     (s_ack),
        .s_err     (s_err),
        .s_dat_r   (s_dat_r),
        .o_owner   (o_owner)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected bus view: idle -> all zero; owner n -> master n's signals, responses to n only.
    task automatic checkAll();
        logic          eCyc, eStb, eWe, e4, e8;
        logic [AW-1:0] eAdr;
        logic [DW-1:0] eDat;
        logic [1:0]    eSel;
        logic [2:0]    eAck, eErr;
        eCyc = 1'b0; eStb = 1'b0; eWe = 1'b0; e4 = 1'b0; e8 = 1'b0;
        eAdr = '0; eDat = '0; eSel = '0; eAck = '0; eErr = '0;
        if (mOwner < 3) begin
            eCyc = m_cyc[mOwner];
            eStb = m_stb[mOwner];
            eWe  = m_we[mOwner];
            e4   = m_4_burst[mOwner];
            e8   = m_8_burst[mOwner];
            eAdr = m_adr[mOwner*AW +: AW];
            eDat = m_dat_w[mOwner*DW +: DW];
            eSel = m_sel[mOwner*2 +: 2];
            eAck[mOwner] = s_ack;
            eErr[mOwner] = s_err;
        end
        checkOutput("o_owner", 64'(o_owner), 64'(mOwner));
        checkOutput("s_cyc", 64'(s_cyc), 64'(eCyc));
        checkOutput("s_stb", 64'(s_stb), 64'(eStb));
        checkOutput("s_we", 64'(s_we), 64'(eWe));
        checkOutput("s_adr", 64'(s_adr), 64'(eAdr));
        checkOutput("s_dat_w", 64'(s_dat_w), 64'(eDat));
        checkOutput("s_sel", 64'(s_sel), 64'(eSel));
        checkOutput("s_burst", 64'({s_4_burst, s_8_burst}), 64'({e4, e8}));
        checkOutput("m_ack", 64'(m_ack), 64'(eAck));
        checkOutput("m_err", 64'(m_err), 64'(eErr));
        checkOutput("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));
    endtask

    // Ownership rules applied at each rising edge.
    task automatic updateModel();
        if (!i_rst) begin
            mOwner = 3;
            mLast  = 2;
        end else if (mOwner == 3) begin
            if (!i_disable) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (mLast + k) % 3;
                    if (m_cyc[c] && mOwner == 3) mOwner = c;
                end
            end
        end else if (!m_cyc[mOwner]) begin
            mLast  = mOwner;
            mOwner = 3;
        end
    endtask

    // One bus cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic applyStimulus(input logic [2:0] cyc, input logic [2:0] stb, input logic [2:0] we,
                                 input logic [2:0] b4, input logic [2:0] b8,
                                 input logic dis, input logic ack, input logic err);
        @(negedge i_clk);
        m_cyc = cyc; m_stb = stb; m_we = we; m_4_burst = b4; m_8_burst = b8;
        i_disable = dis; s_ack = ack; s_err = err;
        for (int n = 0; n < 3; n++) begin
            m_adr[n*AW +: AW]   = AW'($urandom);
            m_dat_w[n*DW +: DW] = DW'($urandom);
        end
        m_sel   = 6'($urandom);
        s_dat_r = DW'($urandom);
        #1 checkAll();
        @(posedge i_clk);
        updateModel();
    endtask

    // Reset asserted mid-cycle while a master owns the bus must clear outputs immediately.
    task automatic asyncResetCheck();
        @(negedge i_clk);
        s_ack = 1'b1;
        #2 i_rst = 1'b0;
        mOwner = 3;
        mLast  = 2;
        #1 checkAll();
        @(posedge i_clk);
        updateModel();
        #2 i_rst = 1'b1;
    endtask

    int         beats [3];
    logic [2:0] act, bst4, bst8, wen, stbR;
    logic       disR, ackR, errR;
    int         ownerNow;

    initial begin
        i_rst = 1'b0; i_disable = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_4_burst = '0; m_8_burst = '0;
        m_adr = '0; m_dat_w = '0; m_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;

        // Held in reset with requests and a stray ack present.
        applyStimulus(3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus(3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        #2 i_rst = 1'b1;

        // M0 and M2 together: M0 first, single-beat read, then M2 after one idle cycle.
        applyStimulus(3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus(3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus(3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0);
        // M2 4-beat write burst while M0 and M1 wait.
        for (int b = 0; b < 4; b++)
            applyStimulus(3'b111, 3'b111, 3'b100, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus(3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // Disable while M1 owns and M0 waits: M1 finishes, bus stays idle until re-enabled.
        applyStimulus(3'b011, 3'b011, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        applyStimulus(3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);
        applyStimulus(3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        // M1 mid-burst, then asynchronous reset; M0 wins first afterwards.
        applyStimulus(3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
        asyncResetCheck();
        applyStimulus(3'b011, 3'b011, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b011, 3'b011, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        // Randomised masters issuing 1/4/8-beat transactions against a random slave.
        act = '0; bst4 = '0; bst8 = '0; wen = '0; disR = 1'b0;
        for (int n = 0; n < 3; n++) beats[n] = 0;
        for (int cy = 0; cy < 800; cy++) begin
            for (int n = 0; n < 3; n++) begin
                if (!act[n] && $urandom_range(3) == 0) begin
                    act[n] = 1'b1;
                    bst4[n] = 1'b0;
                    bst8[n] = 1'b0;
                    case ($urandom_range(2))
                        0: beats[n] = 1;
                        1: begin beats[n] = 4; bst4[n] = 1'b1; end
                        default: begin beats[n] = 8; bst8[n] = 1'b1; end
                    endcase
                    wen[n] = (n == 2) ? 1'($urandom) : 1'b0;
                end
                stbR[n] = act[n] && ($urandom_range(3) != 0);
            end
            if ($urandom_range(19) == 0) disR = ~disR;
            ackR = ($urandom_range(1) == 1);
            errR = ($urandom_range(15) == 0);
            ownerNow = mOwner;
            applyStimulus(act, stbR, wen, bst4, bst8, disR, ackR, errR);
            if (ownerNow < 3 && stbR[ownerNow] && (ackR || errR)) begin
                beats[ownerNow] = beats[ownerNow] - 1;
                if (errR || beats[ownerNow] <= 0) act[ownerNow] = 1'b0;
            end
            if ($urandom_range(63) == 0) act[$urandom_range(2)] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
